// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                      |
// | Description : Shared opcodes, flag bit indices and memory geometry for     |
// |               the 16-bit accumulator processor.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cpu_pkg;

    // Control / branch codes shared with control_unit
    localparam logic [5:0] C_OP_NOP  = 6'd0;
    localparam logic [5:0] C_OP_HLT  = 6'd1;
    localparam logic [5:0] C_OP_JMP  = 6'd2;
    localparam logic [5:0] C_OP_BRZ  = 6'd3;
    localparam logic [5:0] C_OP_BRN  = 6'd4;
    localparam logic [5:0] C_OP_BRC  = 6'd5;
    localparam logic [5:0] C_OP_BRO  = 6'd6;
    localparam logic [5:0] C_OP_CALL = 6'd7;
    localparam logic [5:0] C_OP_RET  = 6'd8;

    // ALU codes
    localparam logic [5:0] C_OP_ADD  = 6'd16;
    localparam logic [5:0] C_OP_SUB  = 6'd17;
    localparam logic [5:0] C_OP_LSR  = 6'd18;
    localparam logic [5:0] C_OP_LSL  = 6'd19;
    localparam logic [5:0] C_OP_ROR  = 6'd20;
    localparam logic [5:0] C_OP_ROL  = 6'd21;
    localparam logic [5:0] C_OP_MUL  = 6'd22;
    localparam logic [5:0] C_OP_DIV  = 6'd23;
    localparam logic [5:0] C_OP_MOD  = 6'd24;
    localparam logic [5:0] C_OP_AND  = 6'd25;
    localparam logic [5:0] C_OP_OR   = 6'd26;
    localparam logic [5:0] C_OP_XOR  = 6'd27;
    localparam logic [5:0] C_OP_NOT  = 6'd28;
    localparam logic [5:0] C_OP_CMP  = 6'd29;
    localparam logic [5:0] C_OP_TST  = 6'd30;
    localparam logic [5:0] C_OP_INC  = 6'd31;
    localparam logic [5:0] C_OP_DEC  = 6'd32;
    localparam logic [5:0] C_OP_MOV  = 6'd33;

    localparam int C_FLAG_Z = 3;
    localparam int C_FLAG_N = 2;
    localparam int C_FLAG_C = 1;
    localparam int C_FLAG_O = 0;

    localparam int C_IM_DEPTH = 1024;
    localparam int C_DM_DEPTH = 512;
    localparam int C_IM_AW    = $clog2(C_IM_DEPTH);
    localparam int C_DM_AW    = $clog2(C_DM_DEPTH);

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_core                                                     |
// | Description : Combinational 16-bit ALU producing result and {Z,N,C,O}.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_core
    import cpu_pkg::*;
(
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic [5:0]  i_opcode,
    input  logic        i_store,
    output logic [15:0] o_result,
    output logic [3:0]  o_flags
);

    logic [16:0] w_sum;
    logic [16:0] w_diff;
    logic [16:0] w_inc;
    logic [16:0] w_dec;
    logic [31:0] w_prod;
    logic [3:0]  w_sh;
    logic [3:0]  w_sh_m1;
    logic [15:0] w_rsh_probe;
    logic [15:0] w_lsh_probe;
    logic        w_carry_r;
    logic        w_carry_l;
    logic        w_div0;
    logic [15:0] w_src;
    logic        w_c;
    logic        w_o;

    assign w_sum   = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff  = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc   = {1'b0, i_a} + 17'd1;
    assign w_dec   = {1'b0, i_a} - 17'd1;
    assign w_prod  = {16'd0, i_a} * {16'd0, i_b};
    assign w_sh    = i_b[3:0];
    assign w_sh_m1 = w_sh - 4'd1;
    assign w_div0  = (i_b == 16'd0);

    // The last bit to leave the word sits one position short of the full shift
    assign w_rsh_probe = i_a >> w_sh_m1;
    assign w_lsh_probe = i_a << w_sh_m1;
    assign w_carry_r   = (w_sh != 4'd0) & w_rsh_probe[0];
    assign w_carry_l   = (w_sh != 4'd0) & w_lsh_probe[15];

    always_comb begin
        w_src = i_a;
        w_c   = 1'b0;
        w_o   = 1'b0;
        if (!i_store) begin
            case (i_opcode)
                C_OP_ADD: begin
                    w_src = w_sum[15:0];
                    w_c   = w_sum[16];
                    w_o   = (i_a[15] == i_b[15]) && (w_sum[15] != i_a[15]);
                end
                C_OP_SUB, C_OP_CMP: begin
                    w_src = w_diff[15:0];
                    w_c   = w_diff[16];
                    w_o   = (i_a[15] != i_b[15]) && (w_diff[15] != i_a[15]);
                end
                C_OP_LSR: begin
                    w_src = i_a >> w_sh;
                    w_c   = w_carry_r;
                end
                C_OP_LSL: begin
                    w_src = i_a << w_sh;
                    w_c   = w_carry_l;
                end
                C_OP_ROR: begin
                    w_src = (i_a >> w_sh) | (i_a << (5'd16 - {1'b0, w_sh}));
                    w_c   = w_carry_r;
                end
                C_OP_ROL: begin
                    w_src = (i_a << w_sh) | (i_a >> (5'd16 - {1'b0, w_sh}));
                    w_c   = w_carry_l;
                end
                C_OP_MUL: begin
                    w_src = w_prod[15:0];
                    w_c   = (w_prod[31:16] != 16'd0);
                end
                C_OP_DIV: begin
                    w_src = w_div0 ? 16'hFFFF : (i_a / i_b);
                    w_o   = w_div0;
                end
                C_OP_MOD: begin
                    w_src = w_div0 ? 16'hFFFF : (i_a % i_b);
                    w_o   = w_div0;
                end
                C_OP_AND: w_src = i_a & i_b;
                C_OP_TST: w_src = i_a & i_b;
                C_OP_OR:  w_src = i_a | i_b;
                C_OP_XOR: w_src = i_a ^ i_b;
                C_OP_NOT: w_src = ~i_a;
                C_OP_INC: begin
                    w_src = w_inc[15:0];
                    w_c   = w_inc[16];
                    w_o   = (i_a == 16'h7FFF);
                end
                C_OP_DEC: begin
                    w_src = w_dec[15:0];
                    w_c   = w_dec[16];
                    w_o   = (i_a == 16'h8000);
                end
                C_OP_MOV: w_src = i_b;
                default:  w_src = i_a;
            endcase
        end
    end

    // CMP and TST only report flags; their visible result stays A
    assign o_result = (i_store || i_opcode == C_OP_CMP || i_opcode == C_OP_TST) ? i_a : w_src;

    always_comb begin
        o_flags           = 4'd0;
        o_flags[C_FLAG_Z] = (w_src == 16'd0);
        o_flags[C_FLAG_N] = w_src[15];
        o_flags[C_FLAG_C] = w_c;
        o_flags[C_FLAG_O] = w_o;
    end

endmodule
`default_nettype wire

// File: rtl/alu_mem_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_mem_unit                                                 |
// | Description : Instruction memory, ALU and stack-capable data memory.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_mem_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                en_write,
    input  logic [C_IM_AW-1:0]  im_address,
    input  logic [15:0]         im_data_in,
    output logic [15:0]         instruction,
    input  logic                store,
    input  logic [15:0]         alu_a,
    input  logic [15:0]         alu_b,
    input  logic [5:0]          opcode,
    output logic [15:0]         alu_out,
    output logic [3:0]          flags,
    input  logic                load,
    input  logic                push,
    input  logic                pop,
    input  logic [C_DM_AW-1:0]  dm_address,
    input  logic [15:0]         rez,
    input  logic [15:0]         sp,
    output logic [15:0]         dm_out
);

    logic [15:0]        r_imem [C_IM_DEPTH];
    logic [15:0]        r_dmem [C_DM_DEPTH];
    logic [C_DM_AW-1:0] w_sp_addr;
    logic [C_DM_AW-1:0] w_pop_addr;
    logic               w_unused_sp_hi;

    // Only the low bits of SP address the data memory; wrap is modulo depth
    assign w_sp_addr      = sp[C_DM_AW-1:0];
    assign w_pop_addr     = w_sp_addr + 9'd1;
    assign w_unused_sp_hi = ^sp[15:C_DM_AW];

    always_ff @(posedge clk) begin
        if (en_write && !reset) begin
            r_imem[im_address] <= im_data_in;
        end
    end

    assign instruction = r_imem[im_address];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_DM_DEPTH; i++) begin
                r_dmem[i] <= 16'd0;
            end
        end else if (push) begin
            r_dmem[w_sp_addr] <= rez;
        end else if (store) begin
            r_dmem[dm_address] <= rez;
        end
    end

    always_comb begin
        dm_out = 16'd0;
        if (pop) begin
            dm_out = r_dmem[w_pop_addr];
        end else if (load) begin
            dm_out = r_dmem[dm_address];
        end
    end

    alu_core u_alu_core (
        .i_a      (alu_a),
        .i_b      (alu_b),
        .i_opcode (opcode),
        .i_store  (store),
        .o_result (alu_out),
        .o_flags  (flags)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_mem_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_mem_unit                                              |
// | Description : Self-checking bench with a behavioural memory/ALU model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_mem_unit;

    logic        clk = 1'b0;
    logic        reset, en_write, store, load, push, pop;
    logic [9:0]  im_address;
    logic [15:0] im_data_in, instruction;
    logic [15:0] alu_a, alu_b, alu_out, rez, sp, dm_out;
    logic [5:0]  opcode;
    logic [3:0]  flags;
    logic [8:0]  dm_address;

    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    logic [15:0] im_m [1024];
    bit          im_v [1024];
    logic [15:0] dm_m [512];

    always #5 clk = ~clk;

    alu_mem_unit dut (
        .clk(clk), .reset(reset), .en_write(en_write), .im_address(im_address),
        .im_data_in(im_data_in), .instruction(instruction), .store(store),
        .alu_a(alu_a), .alu_b(alu_b), .opcode(opcode), .alu_out(alu_out),
        .flags(flags), .load(load), .push(push), .pop(pop),
        .dm_address(dm_address), .rez(rez), .sp(sp), .dm_out(dm_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic bit ovf(input int v);
        return (v > 32767) || (v < -32768);
    endfunction

    // Reference ALU: integer arithmetic and bit-at-a-time shifting
    function automatic void alu_ref(input logic [15:0] a, input logic [15:0] b,
                                    input logic [5:0] op,
                                    output logic [15:0] res, output logic [3:0] fl);
        int          ua, ub, sa, sb;
        longint      p;
        logic [15:0] src;
        logic        c, o;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        src = a; res = a; c = 1'b0; o = 1'b0;
        case (op)
            6'd16: begin src = 16'(ua + ub); c = (ua + ub) > 65535; o = ovf(sa + sb); res = src; end
            6'd17, 6'd29: begin
                src = 16'(ua - ub); c = ua < ub; o = ovf(sa - sb);
                res = (op == 6'd17) ? src : a;
            end
            6'd18: begin for (int k = 0; k < int'(b[3:0]); k++) begin c = src[0];  src = {1'b0, src[15:1]}; end res = src; end
            6'd19: begin for (int k = 0; k < int'(b[3:0]); k++) begin c = src[15]; src = {src[14:0], 1'b0}; end res = src; end
            6'd20: begin for (int k = 0; k < int'(b[3:0]); k++) begin c = src[0];  src = {src[0], src[15:1]}; end res = src; end
            6'd21: begin for (int k = 0; k < int'(b[3:0]); k++) begin c = src[15]; src = {src[14:0], src[15]}; end res = src; end
            6'd22: begin p = longint'(ua) * longint'(ub); src = 16'(p); c = p > 65535; res = src; end
            6'd23: begin src = (ub == 0) ? 16'hFFFF : 16'(ua / ub); o = (ub == 0); res = src; end
            6'd24: begin src = (ub == 0) ? 16'hFFFF : 16'(ua % ub); o = (ub == 0); res = src; end
            6'd25: begin src = a & b; res = src; end
            6'd26: begin src = a | b; res = src; end
            6'd27: begin src = a ^ b; res = src; end
            6'd28: begin src = ~a;    res = src; end
            6'd30: begin src = a & b; res = a; end
            6'd31: begin src = 16'(ua + 1); c = ua == 65535; o = ovf(sa + 1); res = src; end
            6'd32: begin src = 16'(ua - 1); c = ua == 0;     o = ovf(sa - 1); res = src; end
            6'd33: begin src = b; res = src; end
            default: begin src = a; res = a; end
        endcase
        fl = {src == 16'd0, src[15], c, o};
    endfunction

    always @(negedge clk) begin : compare
        logic [15:0] er, ed;
        logic [3:0]  ef;
        logic [8:0]  pa;
        if (chk_en) begin
            alu_ref(alu_a, alu_b, opcode, er, ef);
            if (store) er = alu_a;
            check("alu_out", {16'd0, alu_out}, {16'd0, er});
            if (!store) check("flags", {28'd0, flags}, {28'd0, ef});
            pa = sp[8:0] + 9'd1;
            ed = pop ? dm_m[pa] : (load ? dm_m[dm_address] : 16'd0);
            check("dm_out", {16'd0, dm_out}, {16'd0, ed});
            if (im_v[im_address]) check("instruction", {16'd0, instruction}, {16'd0, im_m[im_address]});
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) dm_m[i] <= 16'd0;
        end else begin
            if (push) dm_m[sp[8:0]] <= rez;
            else if (store) dm_m[dm_address] <= rez;
            if (en_write) begin
                im_m[im_address] <= im_data_in;
                im_v[im_address] <= 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 0; en_write = 0; store = 0; load = 0; push = 0; pop = 0;
        im_address = 0; im_data_in = 0; alu_a = 0; alu_b = 0; opcode = 0;
        dm_address = 0; rez = 0; sp = 0;
    endtask

    task automatic alu_dir(input string name, input logic [5:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] xo, input logic [3:0] xf);
        logic [15:0] mr;
        logic [3:0]  mf;
        opcode = op; alu_a = a; alu_b = b;
        alu_ref(a, b, op, mr, mf);
        check({name, "_model"}, {12'd0, mf, mr}, {12'd0, xf, xo});
        @(negedge clk);
        check(name, {12'd0, flags, alu_out}, {12'd0, xf, xo});
        tick();
    endtask

    task automatic dm_dir(input string name, input logic [15:0] xd);
        @(negedge clk);
        check(name, {16'd0, dm_out}, {16'd0, xd});
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        chk_en = 1;

        // program load
        en_write = 1; im_address = 10'd0; im_data_in = 16'hFFFF; tick();
        im_address = 10'd1; im_data_in = 16'h4004; tick();
        en_write = 0; im_data_in = 16'h1234; tick();
        @(negedge clk);
        check("im_read1", {16'd0, instruction}, 32'h4004);
        tick();

        // ALU directed
        alu_dir("add_ovf", 6'd16, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
        alu_dir("sub_zero", 6'd17, 16'd3, 16'd3, 16'h0000, 4'b1000);
        alu_dir("sub_borrow", 6'd17, 16'd0, 16'd1, 16'hFFFF, 4'b0110);
        alu_dir("inc_wrap", 6'd31, 16'hFFFF, 16'd0, 16'h0000, 4'b1010);
        alu_dir("lsl1", 6'd19, 16'h8001, 16'd1, 16'h0002, 4'b0010);
        alu_dir("ror1", 6'd20, 16'h0001, 16'd1, 16'h8000, 4'b0110);
        alu_dir("div0", 6'd23, 16'd7, 16'd0, 16'hFFFF, 4'b0101);
        alu_dir("cmp_eq", 6'd29, 16'd5, 16'd5, 16'h0005, 4'b1000);
        store = 1; dm_address = 9'h1F0; rez = 16'h0;
        opcode = 6'd16; alu_a = 16'h1111; alu_b = 16'h2222;
        @(negedge clk);
        check("store_pass", {16'd0, alu_out}, 32'h1111);
        tick();

        // DM store / load
        store = 1; dm_address = 9'h010; rez = 16'hBEEF; tick();
        store = 0; load = 1; dm_dir("load_beef", 16'hBEEF); tick();
        load = 0; dm_dir("idle_zero", 16'h0000); tick();

        // read-during-write returns old data
        store = 1; load = 1; rez = 16'h1111; dm_dir("rdw_old", 16'hBEEF); tick();
        store = 0; dm_dir("rdw_new", 16'h1111); tick();
        load = 0;

        // stack
        push = 1; sp = 16'h01FF; rez = 16'h0123; tick();
        push = 0; pop = 1; sp = 16'h01FE; dm_dir("pop_1ff", 16'h0123); tick();
        pop = 0;
        store = 1; dm_address = 9'h060; rez = 16'h5555; tick();
        push = 1; sp = 16'h0050; rez = 16'hAAAA; tick();
        push = 0; store = 0; load = 1; dm_dir("push_prio_dm", 16'h5555); tick();
        load = 0; pop = 1; sp = 16'h004F; dm_dir("push_prio_sp", 16'hAAAA); tick();
        pop = 0;

        // reset clears DM, suppresses the IM write, keeps IM contents
        reset = 1; en_write = 1; im_address = 10'd1; im_data_in = 16'h9999; tick();
        reset = 0; en_write = 0; load = 1;
        dm_address = 9'h010; dm_dir("rst_010", 16'h0000); tick();
        dm_address = 9'h060; dm_dir("rst_060", 16'h0000); tick();
        load = 0; pop = 1; sp = 16'h01FE; dm_dir("rst_1ff", 16'h0000); tick();
        pop = 0;
        @(negedge clk);
        check("im_keep", {16'd0, instruction}, 32'h4004);
        tick();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 199) == 0);
            en_write   = ($urandom_range(0, 7) == 0);
            im_address = 10'($urandom_range(0, 31));
            im_data_in = 16'($urandom);
            opcode     = 6'($urandom_range(0, 40));
            alu_a      = pick();
            alu_b      = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 17)) : pick();
            store      = ($urandom_range(0, 3) == 0);
            push       = ($urandom_range(0, 4) == 0);
            pop        = ($urandom_range(0, 3) == 0);
            load       = ($urandom_range(0, 2) == 0);
            dm_address = $urandom_range(0, 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(496, 511));
            sp         = {7'($urandom), ($urandom_range(0, 1) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(496, 511)))};
            rez        = 16'($urandom);
            tick();
        end

        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
